wash_timer: RTL and testbench



---
 rtl/wash_timer.sv | 190 +++++++++++++++++++
 tb/tb_wash_timer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wash_timer.sv
// wash_timer: countdown timekeeper for the washer display (min/sec/tenths).
// Loads a duration, counts down in 0.1 s ticks, supports pause/resume.
//
// Ports:
//   clk, rst            24 MHz clock, synchronous active-high reset
//   load                pulse: load load_min/load_sec (clamped), tenths = 0
//   load_min, load_sec  binary minutes / seconds to load
//   start               pulse: begin countdown from IDLE, or resume from PAUSE
//   pause               pulse: freeze countdown while running
//   minute, second      binary minutes / seconds remaining
//   second_p            tenths of a second remaining
//   running             high while counting down
//   expired             high while the countdown has reached zero
//   done                one-cycle pulse on reaching zero
module wash_timer #(
  parameter int TICK_DIV = 2400000,
  parameter int MAX_MIN  = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic [3:0] second_p,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] MAXM = 8'(MAX_MIN);
  localparam logic [7:0] MAXS = 8'd59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [7:0]      r_min;
  logic [7:0]      r_sec;
  logic [3:0]      r_ten;
  logic [PW-1:0]   r_pre;
  logic            r_running;
  logic            r_expired;
  logic            r_done;

  state_t          w_state_n;
  logic [7:0]      w_min_n;
  logic [7:0]      w_sec_n;
  logic [3:0]      w_ten_n;
  logic [PW-1:0]   w_pre_n;
  logic            w_done_n;

  logic [7:0]      w_ld_min;
  logic [7:0]      w_ld_sec;
  logic            w_nz;
  logic            w_tick;
  logic [7:0]      w_dmin;
  logic [7:0]      w_dsec;
  logic [3:0]      w_dten;
  logic            w_dzero;

  assign w_ld_min = (load_min > MAXM) ? MAXM : load_min;
  assign w_ld_sec = (load_sec > MAXS) ? MAXS : load_sec;
  assign w_nz     = (r_min != 8'd0) || (r_sec != 8'd0) || (r_ten != 4'd0);
  assign w_tick   = (r_pre == PRE_LAST);

  // Borrow chain: tenths -> seconds -> minutes.
  always_comb begin
    w_dmin = r_min;
    w_dsec = r_sec;
    w_dten = r_ten;
    if (r_ten != 4'd0) begin
      w_dten = r_ten - 4'd1;
    end else if (r_sec != 8'd0) begin
      w_dsec = r_sec - 8'd1;
      w_dten = 4'd9;
    end else if (r_min != 8'd0) begin
      w_dmin = r_min - 8'd1;
      w_dsec = MAXS;
      w_dten = 4'd9;
    end
    w_dzero = (w_dmin == 8'd0) && (w_dsec == 8'd0) && (w_dten == 4'd0);
  end

  always_comb begin
    w_state_n = r_state;
    w_min_n   = r_min;
    w_sec_n   = r_sec;
    w_ten_n   = r_ten;
    w_pre_n   = r_pre;
    w_done_n  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (load) begin
          w_min_n = w_ld_min;
          w_sec_n = w_ld_sec;
          w_ten_n = 4'd0;
          w_pre_n = '0;
        end else if (start && w_nz) begin
          w_state_n = RUN;
          w_pre_n   = '0;
        end
      end
      RUN: begin
        // The cycle pause is sampled still counts as run time, so the
        // prescaler advances (or ticks) before freezing.
        if (w_tick) begin
          w_pre_n = '0;
          w_min_n = w_dmin;
          w_sec_n = w_dsec;
          w_ten_n = w_dten;
          if (w_dzero) begin
            w_state_n = DONE;
            w_done_n  = 1'b1;
          end else if (pause) begin
            w_state_n = PAUSE;
          end
        end else begin
          w_pre_n = r_pre + PW'(1);
          if (pause) begin
            w_state_n = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (load) begin
          w_state_n = IDLE;
          w_min_n   = w_ld_min;
          w_sec_n   = w_ld_sec;
          w_ten_n   = 4'd0;
          w_pre_n   = '0;
        end else if (start) begin
          // Prescaler kept so a partial tenth is not lost.
          w_state_n = RUN;
        end
      end
      DONE: begin
        if (load) begin
          w_state_n = IDLE;
          w_min_n   = w_ld_min;
          w_sec_n   = w_ld_sec;
          w_ten_n   = 4'd0;
          w_pre_n   = '0;
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_min     <= 8'd0;
      r_sec     <= 8'd0;
      r_ten     <= 4'd0;
      r_pre     <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_min     <= w_min_n;
      r_sec     <= w_sec_n;
      r_ten     <= w_ten_n;
      r_pre     <= w_pre_n;
      r_running <= (w_state_n == RUN);
      r_expired <= (w_state_n == DONE);
      r_done    <= w_done_n;
    end
  end

  assign minute   = r_min;
  assign second   = r_sec;
  assign second_p = r_ten;
  assign running  = r_running;
  assign expired  = r_expired;
  assign done     = r_done;

endmodule

// File: tb/tb_wash_timer.sv
// tb_wash_timer: directed self-checking bench for wash_timer.
// Runs with TICK_DIV=4 so one tenth-second is four clock cycles.
module tb_wash_timer;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       pause;
  logic [7:0] minute;
  logic [7:0] second;
  logic [3:0] second_p;
  logic       running;
  logic       expired;
  logic       done;

  int checks = 0;
  int errors = 0;
  int n;
  int pulses;

  wash_timer #(.TICK_DIV(4), .MAX_MIN(99)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .pause    (pause),
    .minute   (minute),
    .second   (second),
    .second_p (second_p),
    .running  (running),
    .expired  (expired),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int m, input int s,
                          input int t);
    chk({tag, ".min"}, int'(minute), m);
    chk({tag, ".sec"}, int'(second), s);
    chk({tag, ".tenth"}, int'(second_p), t);
  endtask

  task automatic chk_flags(input string tag, input int r, input int e,
                           input int d);
    chk({tag, ".running"}, int'(running), r);
    chk({tag, ".expired"}, int'(expired), e);
    chk({tag, ".done"}, int'(done), d);
  endtask

  task automatic do_load(input int m, input int s);
    load     = 1'b1;
    load_min = 8'(m);
    load_sec = 8'(s);
    step();
    load     = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    load_min = 8'd0;
    load_sec = 8'd0;
    start    = 1'b0;
    pause    = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_time("reset", 0, 0, 0);
    chk_flags("reset", 0, 0, 0);

    // 0:02 full countdown: 20 tenths * 4 cycles = 80 cycles.
    do_load(0, 2);
    chk_time("load002", 0, 2, 0);
    chk_flags("load002", 0, 0, 0);
    do_start();
    chk("start002.running", int'(running), 1);
    chk_time("start002", 0, 2, 0);
    n = 0;
    pulses = 0;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
      if (n == 4) chk_time("tick1", 0, 1, 9);
    end
    chk("latency002", n, 80);
    chk_time("expired002", 0, 0, 0);
    chk_flags("expired002", 0, 1, 1);
    step();
    chk_flags("hold_done", 0, 1, 0);
    do_start();
    chk_flags("start_in_done", 0, 1, 0);

    // Load 1:00 from DONE, run; a load mid-run is ignored.
    do_load(1, 0);
    chk_time("load100", 1, 0, 0);
    chk_flags("load100", 0, 0, 0);
    do_start();
    do_load(0, 5);
    step();
    step();
    chk_time("load_in_run", 1, 0, 0);
    chk("load_in_run.running", int'(running), 1);
    step();
    chk_time("borrow", 0, 59, 9);

    // Pause two cycles into a tick, hold 50 cycles, resume.
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("pause.running", int'(running), 0);
    chk_time("pause", 0, 59, 9);
    repeat (50) step();
    chk_time("paused50", 0, 59, 9);
    chk_flags("paused50", 0, 0, 0);
    do_start();
    chk("resume.running", int'(running), 1);
    chk_time("resume0", 0, 59, 9);
    step();
    chk_time("resume1", 0, 59, 9);
    step();
    chk_time("resume2", 0, 59, 8);

    // Reset in the middle of a countdown showing 1:05.3.
    pause = 1'b1;
    step();
    pause = 1'b0;
    do_load(1, 6);
    chk_time("load106", 1, 6, 0);
    do_start();
    repeat (28) step();
    chk_time("run1053", 1, 5, 3);
    chk("run1053.running", int'(running), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_time("midreset", 0, 0, 0);
    chk_flags("midreset", 0, 0, 0);
    step();
    chk("midreset_idle.running", int'(running), 0);

    // Clamping and start-at-zero.
    do_load(200, 75);
    chk_time("clamp", 99, 59, 0);
    do_load(0, 0);
    do_start();
    chk_time("zero_start", 0, 0, 0);
    chk_flags("zero_start", 0, 0, 0);

    // Load and start together: load wins, stays IDLE.
    load     = 1'b1;
    start    = 1'b1;
    load_min = 8'd0;
    load_sec = 8'd3;
    step();
    load  = 1'b0;
    start = 1'b0;
    chk_time("ld_st", 0, 3, 0);
    chk("ld_st.running", int'(running), 0);
    repeat (6) step();
    chk_time("ld_st_hold", 0, 3, 0);

    // Tick and pause coincide at 0:00.1: DONE beats PAUSE.
    do_load(0, 1);
    do_start();
    repeat (36) step();
    chk_time("at001", 0, 0, 1);
    repeat (3) step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk_time("tick_pause", 0, 0, 0);
    chk_flags("tick_pause", 0, 1, 1);
    step();
    chk_flags("tick_pause_hold", 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
